// File: rtl/sram_fifo_pkg.sv
// Shared constants and pointer type for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_DEPTH      = 8;
   localparam int DEF_ADDR_WIDTH = $clog2(DEF_DEPTH);

   // Pointer carries one extra wrap bit above the SRAM address.
   typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/sram_fifo_ptr.sv
// Enable-gated FIFO pointer: SRAM address in the low bits, wrap bit on top.
module sram_fifo_ptr
   import sram_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inc,
   output logic [ADDR_WIDTH:0]   ptr
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         ptr <= '0;
      else if (inc)
         ptr <= ptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
   end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Single-clock FIFO controller around a dual-port SRAM (port A write, port B read).
// Optional sticky overflow/underflow flags are enabled by defining SRAM_FIFO_ERR_EN.
module sram_fifo_ctrl
   import sram_fifo_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  pop,
   output logic                  rd_valid,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr,
   output logic                  sram_chip_sel,
   output logic                  sram_read_ena_a,
   output logic [ADDR_WIDTH-1:0] sram_address_a,
   output logic [WIDTH-1:0]      sram_data_in_a,
   output logic                  sram_read_ena_b,
   output logic [ADDR_WIDTH-1:0] sram_address_b,
   input  logic [WIDTH-1:0]      sram_data_out_b
);

   logic [ADDR_WIDTH:0] wr_ptr;
   logic [ADDR_WIDTH:0] rd_ptr;
   logic                push_accept;
   logic                pop_accept;

   sram_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (push_accept),
      .ptr   (wr_ptr)
   );

   sram_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (pop_accept),
      .ptr   (rd_ptr)
   );

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                  (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
   assign count = wr_ptr - rd_ptr;

   // Full blocks pushes even with a same-cycle pop, so ports never hit one address.
   assign wr_ready    = !full && sram_chip_sel;
   assign push_accept = wr_valid && wr_ready;
   assign pop_accept  = pop && !empty;

   assign sram_address_a  = wr_ptr[ADDR_WIDTH-1:0];
   assign sram_data_in_a  = wr_data;
   assign sram_read_ena_a = !push_accept;
   assign sram_read_ena_b = 1'b1;
   assign sram_address_b  = rd_ptr[ADDR_WIDTH-1:0];
   assign rd_data         = sram_data_out_b;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sram_chip_sel <= 1'b0;
         rd_valid      <= 1'b0;
      end else begin
         sram_chip_sel <= 1'b1;
         rd_valid      <= pop_accept;
      end
   end

`ifdef SRAM_FIFO_ERR_EN
   // Set has priority over a same-cycle clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_valid && full)
            overflow <= 1'b1;
         else if (err_clr)
            overflow <= 1'b0;
         if (pop && empty)
            underflow <= 1'b1;
         else if (err_clr)
            underflow <= 1'b0;
      end
   end
`else
   // Flags disabled: err_clr stays on the port but has no effect.
   assign overflow  = err_clr & 1'b0;
   assign underflow = err_clr & 1'b0;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural dual-port SRAM attached.
module tb_sram_fifo_ctrl;

`ifdef SRAM_FIFO_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_valid, wr_ready, pop, rd_valid, full, empty;
   logic [7:0] wr_data, rd_data;
   logic [3:0] count;
   logic       overflow, underflow, err_clr;
   logic       sram_chip_sel, sram_read_ena_a, sram_read_ena_b;
   logic [2:0] sram_address_a, sram_address_b;
   logic [7:0] sram_data_in_a, sram_data_out_b;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   sram_fifo_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .wr_valid        (wr_valid),
      .wr_ready        (wr_ready),
      .wr_data         (wr_data),
      .pop             (pop),
      .rd_valid        (rd_valid),
      .rd_data         (rd_data),
      .full            (full),
      .empty           (empty),
      .count           (count),
      .overflow        (overflow),
      .underflow       (underflow),
      .err_clr         (err_clr),
      .sram_chip_sel   (sram_chip_sel),
      .sram_read_ena_a (sram_read_ena_a),
      .sram_address_a  (sram_address_a),
      .sram_data_in_a  (sram_data_in_a),
      .sram_read_ena_b (sram_read_ena_b),
      .sram_address_b  (sram_address_b),
      .sram_data_out_b (sram_data_out_b)
   );

   // dual_sram stand-in: read_ena low writes, port B registered read.
   logic [7:0] mem [8];
   always @(posedge clk) begin
      if (sram_chip_sel) begin
         if (!sram_read_ena_a) mem[sram_address_a] <= sram_data_in_a;
         if (sram_read_ena_b)  sram_data_out_b <= mem[sram_address_b];
      end
   end

   typedef struct {
      logic       wv;
      logic [7:0] wd;
      logic       pp;
      logic       clr;
      int         cnt;
      logic       full;
      logic       empty;
      logic       wrdy;
      logic       rv;
      logic [7:0] rd;
      logic       ovf;
      logic       udf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic wv, logic [7:0] wd, logic pp, logic clr, int cnt,
                               logic f, logic e, logic wrdy, logic rv, logic [7:0] rd,
                               logic ovf, logic udf);
      vec_t v;
      v.wv = wv; v.wd = wd; v.pp = pp; v.clr = clr; v.cnt = cnt;
      v.full = f; v.empty = e; v.wrdy = wrdy; v.rv = rv; v.rd = rd;
      v.ovf = ovf; v.udf = udf;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wv, input logic [7:0] wd, input logic pp, input logic clr);
      wr_valid = wv;
      wr_data  = wd;
      pop      = pp;
      err_clr  = clr;
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] exp_d;
      logic       do_push, do_pop;
      int         n_push;
      string      tag;

      reset = 1'b0;
      drive(0, 8'h00, 0, 0);

      // table: each row is inputs for one edge and the status expected after it
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 8'hAA, 0, 0, 1, 0, 0, 1, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 1, 8'hAA, 0, 0));
      for (int i = 1; i <= 8; i++)
         tbl.push_back(mk(1, 8'(i), 0, 0, i, i == 8, 0, i != 8, 0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 8'h09, 0, 0, 8, 1, 0, 0, 0, 8'h00, 1, 0));
      tbl.push_back(mk(0, 8'h00, 0, 1, 8, 1, 0, 0, 0, 8'h00, 0, 0));
      for (int i = 1; i <= 8; i++)
         tbl.push_back(mk(0, 8'h00, 1, 0, 8 - i, 0, i == 8, 1, 1, 8'(i), 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 0, 8'h00, 0, 1));
      tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 1, 1, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 1, 1, 0, 8'h00, 0, 1));
      tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 1, 1, 0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 8'h77, 1, 0, 1, 0, 0, 1, 0, 8'h00, 0, 1));
      tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 1, 1, 1, 8'h77, 0, 0));
      tbl.push_back(mk(1, 8'hB1, 0, 0, 1, 0, 0, 1, 0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 8'hB2, 0, 0, 2, 0, 0, 1, 0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 8'hB3, 0, 0, 3, 0, 0, 1, 0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 8'hB4, 1, 0, 3, 0, 0, 1, 1, 8'hB1, 0, 0));
      for (int i = 5; i <= 9; i++)
         tbl.push_back(mk(1, 8'hB0 + 8'(i), 0, 0, i - 1, i == 9, 0, i != 9, 0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 8'hBA, 1, 0, 7, 0, 0, 1, 1, 8'hB2, 1, 0));
      tbl.push_back(mk(0, 8'h00, 0, 1, 7, 0, 0, 1, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 6, 0, 0, 1, 1, 8'hB3, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 5, 0, 0, 1, 1, 8'hB4, 0, 0));

      #12;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_chip_sel", sram_chip_sel, 0);
      chk("rst_rena_a", sram_read_ena_a, 1);
      chk("rst_rena_b", sram_read_ena_b, 1);
      chk("rst_ovf", overflow, 0);
      chk("rst_udf", underflow, 0);

      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("rel_chip_sel", sram_chip_sel, 1);
      chk("rel_wr_ready", wr_ready, 1);

      foreach (tbl[i]) begin
         drive(tbl[i].wv, tbl[i].wd, tbl[i].pp, tbl[i].clr);
         tick();
         tag = $sformatf("v%0d", i);
         chk({tag, "_count"}, count, tbl[i].cnt);
         chk({tag, "_full"}, full, tbl[i].full);
         chk({tag, "_empty"}, empty, tbl[i].empty);
         chk({tag, "_wr_ready"}, wr_ready, tbl[i].wrdy);
         chk({tag, "_rd_valid"}, rd_valid, tbl[i].rv);
         if (tbl[i].rv)
            chk({tag, "_rd_data"}, rd_data, tbl[i].rd);
         chk({tag, "_ovf"}, overflow, tbl[i].ovf & ERR_EN);
         chk({tag, "_udf"}, underflow, tbl[i].udf & ERR_EN);
      end

      // mid-stream reset with count=5 and a push pending
      drive(1, 8'hEE, 0, 0);
      #2 reset = 1'b0;
      #1;
      chk("mid_count", count, 0);
      chk("mid_empty", empty, 1);
      chk("mid_full", full, 0);
      chk("mid_wr_ready", wr_ready, 0);
      chk("mid_rd_valid", rd_valid, 0);
      chk("mid_chip_sel", sram_chip_sel, 0);
      chk("mid_rena_a", sram_read_ena_a, 1);
      chk("mid_ovf", overflow, 0);
      drive(0, 8'h00, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("mid_rel_chip_sel", sram_chip_sel, 1);
      drive(1, 8'h5A, 0, 0);
      tick();
      chk("mid_push_count", count, 1);
      drive(0, 8'h00, 1, 0);
      tick();
      chk("mid_pop_rd_valid", rd_valid, 1);
      chk("mid_pop_rd_data", rd_data, 8'h5A);
      chk("mid_pop_empty", empty, 1);
      drive(0, 8'h00, 0, 0);

      // wrap: 4 pushes, 8 push+pop, 4 pops, starting from address 0
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      tick();
      n_push = 0;
      for (int k = 0; k < 16; k++) begin
         do_push = (k < 12);
         do_pop  = (k >= 4);
         drive(do_push, 8'hC0 + 8'(n_push), do_pop, 0);
         #1;
         if (do_push) begin
            chk($sformatf("wrap%0d_addr_a", k), sram_address_a, n_push % 8);
            chk($sformatf("wrap%0d_rena_a", k), sram_read_ena_a, 0);
            q.push_back(8'hC0 + 8'(n_push));
            n_push++;
         end
         exp_d = 8'h00;
         if (do_pop) exp_d = q.pop_front();
         tick();
         chk($sformatf("wrap%0d_count", k), count, q.size());
         chk($sformatf("wrap%0d_rd_valid", k), rd_valid, do_pop);
         if (do_pop)
            chk($sformatf("wrap%0d_rd_data", k), rd_data, exp_d);
      end
      drive(0, 8'h00, 0, 0);
      tick();
      chk("wrap_end_empty", empty, 1);
      chk("wrap_end_rd_valid", rd_valid, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

Synchronous FIFO controller that turns the `dual_sram` block into a single-clock queue. Port A of the SRAM is used write-only, driven by a producer-side valid/ready push interface. Port B is used read-only, driven by a consumer-side pop interface with one-cycle read latency. The controller owns the pointers, full/empty/count status and error flags; the SRAM holds the data.

## Interface
- `WIDTH`, 8, data word width; must match `dual_sram`.
- `DEPTH`, 8, number of entries; power of two, ≥2.
- `ADDR_WIDTH`, $clog2(DEPTH), SRAM address width.
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  producer has a word.
- `wr_ready`  out  1  push can be accepted.
- `wr_data`  in  WIDTH  word to push.
- `pop`  in  1  consumer requests one word.
- `rd_valid`  out  1  `rd_data` holds a popped word this cycle.
- `rd_data`  out  WIDTH  popped word, straight from `sram_data_out_b`.
- `full`, `empty`  out  1  status.
- `count`  out  ADDR_WIDTH+1  occupied entries, 0..DEPTH.
- `overflow`, `underflow`  out  1  sticky error flags.
- `err_clr`  in  1  clears sticky flags.
- `sram_chip_sel`  out  1  to SRAM `chip_sel`.
- `sram_read_ena_a`, `sram_address_a`, `sram_data_in_a`  out  1/ADDR_WIDTH/WIDTH  SRAM port A.
- `sram_read_ena_b`, `sram_address_b`  out  1/ADDR_WIDTH  SRAM port B.
- `sram_data_out_b`  in  WIDTH  SRAM port B read data.

## Operation
- Pointers `wr_ptr` and `rd_ptr` are ADDR_WIDTH+1 bits wide. The MSB is a wrap bit; the low bits are the SRAM address.
- Status decode:
  - `empty` when `wr_ptr == rd_ptr`.
  - `full` when the low bits are equal and the MSBs differ.
  - `count = wr_ptr - rd_ptr`, modulo 2^(ADDR_WIDTH+1).
- `sram_chip_sel` is a register: 0 in reset, 1 from the first edge after reset release.
- `wr_ready = !full && sram_chip_sel`.
- A push is accepted when `wr_valid && wr_ready`.
- Port A, combinational:
  - `sram_address_a = wr_ptr[ADDR_WIDTH-1:0]`.
  - `sram_data_in_a = wr_data`.
  - `sram_read_ena_a = !push_accept`, so the SRAM writes only on accepted pushes.
- Port B, combinational:
  - `sram_read_ena_b = 1` always; port B never writes.
  - `sram_address_b = rd_ptr[ADDR_WIDTH-1:0]`.
- A pop is accepted when `pop && !empty`. The edge that accepts it increments `rd_ptr` and sets `rd_valid` for the next cycle.
- Simultaneous push and pop:
  - Both act in the same cycle and `count` is unchanged.
  - A push while `full` is rejected even if a pop happens in the same cycle. This avoids same-address read/write across ports.
  - A pop while `empty` is rejected even if a push happens in the same cycle.
- Wrap-around: pointers wrap naturally at 2^(ADDR_WIDTH+1); no special handling is needed.
- Error flags:
  - `overflow` sets on `wr_valid && full`.
  - `underflow` sets on `pop && empty`.
  - `err_clr` clears both; set wins over a same-cycle clear.

## Timing
- Reset values: pointers 0, `empty=1`, `full=0`, `count=0`, `wr_ready=0`, `rd_valid=0`, `overflow=0`, `underflow=0`, `sram_chip_sel=0`.
- Behaviour during reset: `sram_read_ena_a=1` and `sram_read_ena_b=1`, so no SRAM write can occur. `rd_data` is undefined while `rd_valid=0`.
- Push latency: a push accepted at edge E is written at E. `empty` falls and `count` updates after E. A pop at E+1 returns that word.
- Pop latency: a pop accepted at edge E gives `rd_valid=1` with the data in cycle E..E+1. Back-to-back pops stream one word per cycle.
- Reset asserted mid-operation: state clears immediately and asynchronously, and the FIFO is empty. SRAM contents are not cleared but are unreachable.

## Configuration
- `SRAM_FIFO_ERR_EN`:
  - Defined: `overflow`/`underflow` sticky logic and `err_clr` behave as above.
  - Undefined: both flags are tied to 0 and `err_clr` is ignored; the ports remain present.

## Structure
- Package `sram_fifo_pkg` holds the default `WIDTH`/`DEPTH` constants and a pointer typedef (ADDR_WIDTH+1 bits).
- Sub-module `sram_fifo_ptr` is an enable-gated pointer register with wrap bit and async active-low reset. It is instantiated twice, once for write and once for read.
- The top level instantiates the controller only. `dual_sram` is connected alongside it in the integration level.

## Test plan
All scenarios use DEPTH=8, WIDTH=8, with `dual_sram` attached.
- Reset, then push 0xAA: `count=1`, `empty=0`. Pop next cycle: `rd_valid=1`, `rd_data=0xAA`, then `empty=1`.
- Push 0x01..0x08 back-to-back: `full=1`, `wr_ready=0` after the 8th. A 9th push attempt leaves `count=8` and sets `overflow=1`. Then `err_clr` clears it.
- Drain all 8 with continuous pop: `rd_data` is 0x01..0x08 on consecutive cycles, then `empty=1`. An extra pop sets `underflow=1` with no `rd_valid`.
- Wrap: push 12 and pop 12 interleaved with `count` holding at 4. Data order is preserved across the address wrap, and `sram_address_a` cycles 0..7,0..3.
- Simultaneous push and pop at `count=3`: `count` stays 3 and the popped data is correct. Push while full with a same-cycle pop is rejected.
- Assert `reset` mid-stream with `count=5`: outputs return to reset values immediately and `sram_chip_sel=0`. After release, a push of 0x5A then a pop returns 0x5A.
